jt12_sh_slot_wr: RTL

- Recirculating time-division register ring: `stages` words of `width` bits rotate once per `cen` tick. One word is presented per slot at `drop`.
- A CPU-side write port injects a new word into a chosen slot when that slot passes the ring input. It uses a req/busy/done handshake.
- It is the writer end of the per-slot shift-register storage: the FM core reads `drop`, and the register interface writes through this block.

---
 rtl/jt12_sh_slot_wr.sv | 92 +++++++++
 1 files changed

// File: rtl/jt12_sh_slot_wr.sv
// Recirculating per-slot register ring with a CPU-side write port.
// A pending write replaces the word of its target slot as that slot passes the ring input.
module jt12_sh_slot_wr #(
  parameter int   width  = 8,
  parameter int   stages = 24,
  parameter int   slotw  = 5,
  parameter logic rstval = 1'b0
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             cen,
  input  logic             wr_req,
  input  logic [slotw-1:0] wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_done,
  output logic             wr_err,
  output logic [slotw-1:0] cur_slot,
  output logic [width-1:0] drop
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [slotw-1:0] LAST_SLOT = slotw'(stages - 1);
  localparam logic [slotw:0]   NSTAGES   = (slotw + 1)'(stages);

  logic [width-1:0] ring [stages];
  logic [1:0]       state;
  logic [slotw-1:0] slot_q;
  logic [width-1:0] data_q;
  logic             err_q;
  logic             substitute;

  assign drop       = ring[stages-1];
  assign substitute = (state == WAIT) && cen && (cur_slot == slot_q);

  // ring[0] is the input, ring[stages-1] is the word currently at drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < stages; i++) ring[i] <= {width{rstval}};
    end else if (cen) begin
      ring[0] <= substitute ? data_q : drop;
      for (int i = 1; i < stages; i++) ring[i] <= ring[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot <= '0;
    end else if (cen) begin
      cur_slot <= (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;
    end
  end

  // Out-of-range slots skip WAIT so the request completes without touching the ring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      slot_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            slot_q <= wr_slot;
            data_q <= wr_data;
            if ({1'b0, wr_slot} >= NSTAGES) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (substitute) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_busy = (state != IDLE);
  assign wr_done = (state == DONE);
  assign wr_err  = (state == DONE) && err_q;

endmodule
